cryptor: RTL and testbench



---
 rtl/cryptor.sv | 60 ++++++
 tb/tb_cryptor.sv | 119 +++++++++++
 2 files changed

// File: rtl/cryptor.sv
// One-time-pad XOR datapath with optional consecutive key-reuse monitor.
// Monitor is built only when CRYPTOR_REUSE_CHECK_EN is defined.
module cryptor #(
  parameter int KEY_SIZE = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [KEY_SIZE-1:0] msg,
  input  logic [KEY_SIZE-1:0] key,
  output logic [KEY_SIZE-1:0] out,
  output logic                out_valid,
  output logic                key_reuse
);

  logic [KEY_SIZE-1:0] r_out;
  logic                r_valid;
  logic [KEY_SIZE-1:0] w_xor;

  assign w_xor = msg ^ key;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_out   <= w_xor;
      r_valid <= 1'b1;
    end
  end

  assign out       = r_out;
  assign out_valid = r_valid;

`ifdef CRYPTOR_REUSE_CHECK_EN
  logic [KEY_SIZE-1:0] r_last_key;
  logic                r_last_ok;
  logic                r_reuse;
  logic                w_same;

  assign w_same = r_last_ok && (key == r_last_key);

  // Advisory only: never gates the datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_key <= '0;
      r_last_ok  <= 1'b0;
      r_reuse    <= 1'b0;
    end else begin
      r_reuse    <= w_same;
      r_last_key <= key;
      r_last_ok  <= 1'b1;
    end
  end

  assign key_reuse = r_reuse;
`else
  assign key_reuse = 1'b0;
`endif

endmodule

// File: tb/tb_cryptor.sv
// Directed and random self-checking bench for cryptor.
module tb_cryptor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] msg;
  logic [31:0] key;
  logic [31:0] out;
  logic        out_valid;
  logic        key_reuse;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_last;
  logic        m_ok;

`ifdef CRYPTOR_REUSE_CHECK_EN
  localparam bit REUSE_EN = 1'b1;
`else
  localparam bit REUSE_EN = 1'b0;
`endif

  cryptor #(.KEY_SIZE(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .msg       (msg),
    .key       (key),
    .out       (out),
    .out_valid (out_valid),
    .key_reuse (key_reuse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [31:0] m, input logic [31:0] k);
    msg = m;
    key = k;
    @(posedge clk);
    #1;
  endtask

  // Drive one word, then check out/out_valid/key_reuse against the model.
  task automatic xfer(input string tag,
                      input logic [31:0] m,
                      input logic [31:0] k,
                      input logic [31:0] exp_out);
    logic exp_reuse;
    exp_reuse = REUSE_EN && m_ok && (k == m_last);
    m_last = k;
    m_ok   = 1'b1;
    step(m, k);
    chk({tag, "_out"}, out, exp_out);
    chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_reuse"}, {31'd0, key_reuse}, {31'd0, exp_reuse});
  endtask

  task automatic do_reset(input logic [31:0] m, input logic [31:0] k);
    rst = 1'b1;
    m_last = '0;
    m_ok   = 1'b0;
    step(m, k);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] rm, rk, pk;
    rst = 1'b1;
    msg = '0;
    key = '0;
    m_last = '0;
    m_ok   = 1'b0;

    do_reset(32'h1234_5678, 32'h9ABC_DEF0);
    chk("rst_out", out, 32'h0);
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_reuse", {31'd0, key_reuse}, 32'd0);

    xfer("t1", 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    xfer("t2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    xfer("t3a", 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF);
    xfer("t3b", 32'h5555_5555, 32'h5555_5555, 32'h0000_0000);
    xfer("t4a", 32'hFFFF_FFFF, 32'h5555_5555, 32'hAAAA_AAAA);
    xfer("t4b", 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF);
    xfer("zkey", 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF);
    xfer("okey", 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h2152_4110);
    xfer("mix", 32'h0F0F_1234, 32'h00FF_F0F0, 32'h0FF0_E2C4);
    xfer("nadj", 32'h1111_1111, 32'hFFFF_FFFF, 32'hEEEE_EEEE);

    do_reset(32'hCAFE_F00D, 32'hFFFF_FFFF);
    chk("mrst_out", out, 32'h0);
    chk("mrst_vld", {31'd0, out_valid}, 32'd0);
    chk("mrst_reuse", {31'd0, key_reuse}, 32'd0);
    xfer("post", 32'h0000_FFFF, 32'hFFFF_FFFF, 32'hFFFF_0000);
    xfer("post2", 32'h1234_0000, 32'hFFFF_FFFF, 32'hEDCB_FFFF);

    pk = 32'hFFFF_FFFF;
    for (int i = 0; i < 1000; i++) begin
      rm = $urandom;
      rk = ($urandom_range(0, 3) == 0) ? pk : $urandom;
      xfer("rnd", rm, rk, rm ^ rk);
      pk = rk;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
